// File: rtl/mux_scan_ctrl.sv
// Sweeps a 4:1 mux across enabled channels, settling dwell+1 cycles per channel, and captures y per channel.
// Latency: (dwell+1) cycles per enabled channel plus one start cycle; no backpressure, valid is a one-cycle pulse.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s1,
  output logic               s0,
  output logic [3:0]         data,
  output logic               valid,
  output logic               busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [1:0]         sel;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_l;
  logic [3:0]         mask_l;
  logic [3:0]         shadow;
  logic [3:0]         cap;
  logic [1:0]         first_ch;
  logic [1:0]         next_ch;
  logic               has_next;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Next channel is searched in the latched mask so live mask changes cannot disturb a sweep.
  always_comb begin
    first_ch = lowest_ch(mask);
    has_next = 1'b0;
    next_ch  = sel;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(sel) && mask_l[i]) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
    cap      = shadow;
    cap[sel] = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      dwell_l <= '0;
      mask_l  <= 4'd0;
      shadow  <= 4'd0;
      data    <= 4'd0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && mask != 4'd0) begin
            mask_l  <= mask;
            dwell_l <= dwell;
            sel     <= first_ch;
            cnt     <= dwell;
            shadow  <= 4'd0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else if (has_next) begin
            shadow <= cap;
            sel    <= next_ch;
            cnt    <= dwell_l;
          end else begin
            data   <= cap;
            valid  <= 1'b1;
            shadow <= 4'd0;
            // Back-to-back restart in continuous mode: no idle cycle between sweeps.
            if (cont && mask != 4'd0) begin
              mask_l  <= mask;
              dwell_l <= dwell;
              sel     <= first_ch;
              cnt     <= dwell;
            end else begin
              state <= IDLE;
              sel   <= 2'd0;
              cnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = (state == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: per-cycle vector table plus hand sequences for async reset mid-sweep.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] mask;
  logic [3:0] dwell;
  logic [3:0] pat;
  logic       y;
  logic       s1, s0;
  logic [3:0] data;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cont  (cont),
    .mask  (mask),
    .dwell (dwell),
    .y     (y),
    .s1    (s1),
    .s0    (s0),
    .data  (data),
    .valid (valid),
    .busy  (busy)
  );

  // Scanned mux model: y = I[{s1,s0}]
  assign y = pat[{s1, s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic       cont;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic [3:0] pat;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_valid;
    logic [3:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic st, logic c, logic [3:0] m, logic [3:0] d,
                              logic [3:0] p, logic [1:0] es, logic eb, logic ev,
                              logic [3:0] ed);
    vec_t v;
    v.rst = r; v.start = st; v.cont = c; v.mask = m; v.dwell = d; v.pat = p;
    v.e_sel = es; v.e_busy = eb; v.e_valid = ev; v.e_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] es, input logic eb,
                            input logic ev, input logic [3:0] ed);
    check({tag, "_sel"},   {6'd0, s1, s0}, {6'd0, es});
    check({tag, "_busy"},  {7'd0, busy},   {7'd0, eb});
    check({tag, "_valid"}, {7'd0, valid},  {7'd0, ev});
    check({tag, "_data"},  {4'd0, data},   {4'd0, ed});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; mask = 4'd0; dwell = 4'd0; pat = 4'd0;

    // reset state
    tbl.push_back(mk(1,0,0,4'h0,0,4'h0, 2'd0,0,0,4'h0));
    // dwell 0, all channels, I=1010
    tbl.push_back(mk(0,1,0,4'hF,0,4'hA, 2'd0,1,0,4'h0));
    tbl.push_back(mk(0,0,0,4'hF,0,4'hA, 2'd1,1,0,4'h0));
    tbl.push_back(mk(0,0,0,4'hF,0,4'hA, 2'd2,1,0,4'h0));
    tbl.push_back(mk(0,0,0,4'hF,0,4'hA, 2'd3,1,0,4'h0));
    tbl.push_back(mk(0,0,0,4'hF,0,4'hA, 2'd0,0,1,4'hA));
    tbl.push_back(mk(0,0,0,4'hF,0,4'hA, 2'd0,0,0,4'hA));
    // mask 0101, dwell 2, I=0110: channels 1 and 3 never selected
    tbl.push_back(mk(0,1,0,4'h5,2,4'h6, 2'd0,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd0,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd0,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd2,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd2,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd2,1,0,4'hA));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd0,0,1,4'h4));
    tbl.push_back(mk(0,0,0,4'h5,2,4'h6, 2'd0,0,0,4'h4));
    // start with empty mask is ignored
    tbl.push_back(mk(0,1,0,4'h0,0,4'h6, 2'd0,0,0,4'h4));
    tbl.push_back(mk(0,1,0,4'h0,0,4'h6, 2'd0,0,0,4'h4));
    // mask/dwell/start changes mid-sweep have no effect, I=1001, dwell 1
    tbl.push_back(mk(0,1,0,4'hF,1,4'h9, 2'd0,1,0,4'h4));
    tbl.push_back(mk(0,1,0,4'h1,1,4'h9, 2'd0,1,0,4'h4));
    tbl.push_back(mk(0,1,0,4'h1,1,4'h9, 2'd1,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd1,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd2,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd2,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd3,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd3,1,0,4'h4));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd0,0,1,4'h9));
    tbl.push_back(mk(0,0,0,4'h1,3,4'h9, 2'd0,0,0,4'h9));
    // continuous mode: three back-to-back sweeps, cont dropped during the third
    tbl.push_back(mk(0,1,1,4'hF,0,4'h3, 2'd0,1,0,4'h9));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h3, 2'd1,1,0,4'h9));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h3, 2'd2,1,0,4'h9));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h3, 2'd3,1,0,4'h9));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h3, 2'd0,1,1,4'h3));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h5, 2'd1,1,0,4'h3));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h5, 2'd2,1,0,4'h3));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h5, 2'd3,1,0,4'h3));
    tbl.push_back(mk(0,0,1,4'hF,0,4'h5, 2'd0,1,1,4'h5));
    tbl.push_back(mk(0,0,0,4'hF,0,4'h6, 2'd1,1,0,4'h5));
    tbl.push_back(mk(0,0,0,4'hF,0,4'h6, 2'd2,1,0,4'h5));
    tbl.push_back(mk(0,0,0,4'hF,0,4'h6, 2'd3,1,0,4'h5));
    tbl.push_back(mk(0,0,0,4'hF,0,4'h6, 2'd0,0,1,4'h6));
    tbl.push_back(mk(0,0,0,4'hF,0,4'h6, 2'd0,0,0,4'h6));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start; cont = tbl[i].cont;
      mask = tbl[i].mask; dwell = tbl[i].dwell; pat = tbl[i].pat;
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_valid, tbl[i].e_data);
    end

    // Async reset while channel 2 is selected
    @(negedge clk);
    start = 1'b1; cont = 1'b0; mask = 4'hF; dwell = 4'd3; pat = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit reached = 1'b0;
      for (int k = 0; k < 40 && !reached; k++) begin
        if ({s1, s0} == 2'd2) reached = 1'b1;
        else begin
          @(posedge clk); #1;
          check("rst_seq_no_valid", {7'd0, valid}, 8'd0);
        end
      end
      check("rst_seq_reach_ch2", {7'd0, reached}, 8'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 2'd0, 1'b0, 1'b0, 4'h0);
    @(posedge clk); #1;
    check_outs("rst_held", 2'd0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("post_rst_idle%0d", k), 2'd0, 1'b0, 1'b0, 4'h0);
    end

    // Fresh sweep after reset: mask 0110, I=0010
    @(negedge clk);
    start = 1'b1; mask = 4'h6; dwell = 4'd0; pat = 4'h2;
    @(posedge clk); #1;
    check_outs("fresh0", 2'd1, 1'b1, 1'b0, 4'h0);
    start = 1'b0;
    @(posedge clk); #1;
    check_outs("fresh1", 2'd2, 1'b1, 1'b0, 4'h0);
    @(posedge clk); #1;
    check_outs("fresh_end", 2'd0, 1'b0, 1'b1, 4'h2);
    @(posedge clk); #1;
    check_outs("fresh_hold", 2'd0, 1'b0, 1'b0, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of the per-channel settle count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL have port cont  input  1  continuous mode; evaluated at end of each sweep.
REQ-006 SHALL have port mask  input  4  channel enables; bit n enables mux input n.
REQ-007 SHALL have port dwell  input  DWELL_W  extra settle cycles per channel.
REQ-008 SHALL have port y  input  1  output of the downstream 4:1 mux being scanned.
REQ-009 SHALL have ports s1, s0  output  1 each  registered mux select; channel n = {s1,s0}.
REQ-010 SHALL have port data  output  4  captured sweep result; bit n = sampled y for channel n.
REQ-011 SHALL have port valid  output  1  one-cycle pulse marking a new data value.
REQ-012 SHALL have port busy  output  1  high while a sweep is in progress.

Function
REQ-013 SHALL implement two states: IDLE and SCAN.
REQ-014 In IDLE, start=1 with mask!=0 SHALL latch mask and dwell, load {s1,s0} with the lowest enabled channel, load the dwell counter with dwell, and enter SCAN on the next edge.
REQ-015 In IDLE, start=1 with mask==0 SHALL be ignored: no state change, no valid.
REQ-016 In SCAN, start SHALL be ignored, and changes to mask and dwell SHALL have no effect on the sweep in progress.
REQ-017 In SCAN, a nonzero dwell counter SHALL decrement by one per cycle with {s1,s0} held.
REQ-018 In SCAN, a zero counter SHALL capture y into the shadow bit of the current channel at that edge; each enabled channel SHALL therefore occupy exactly dwell+1 cycles.
REQ-019 After a capture, if a higher-index enabled channel remains, {s1,s0} SHALL move to the next such channel (disabled channels skipped, never driven) and the counter SHALL reload with the latched dwell.
REQ-020 Capturing the highest enabled channel SHALL end the sweep: data <= shadow including that capture, disabled-channel bits 0, and valid=1 for exactly one cycle.
REQ-021 At sweep end with cont=1 and current mask!=0, mask and dwell SHALL be re-latched and the next sweep SHALL start at the lowest enabled channel with no idle cycle.
REQ-022 At sweep end otherwise, the block SHALL return to IDLE with {s1,s0}=00.
REQ-023 The shadow register SHALL clear at the start of every sweep.
REQ-024 busy SHALL equal (state==SCAN); valid SHALL never be high in a cycle with no sweep end.
REQ-025 dwell=0 SHALL be legal: one cycle per enabled channel.
REQ-026 data SHALL hold its last value until the next sweep end or reset.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, s1=0, s0=0, data=0000, valid=0, busy=0, with the counter and shadow cleared.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no valid pulse and no partial data update.
REQ-029 After rst deasserts, the block SHALL stay in IDLE until a qualifying start.

Verification
Bench models the mux as y = I[{s1,s0}].
REQ-030 Scenario 1: I=4'b1010, mask=1111, dwell=0, start pulse -> {s1,s0} = 00,01,10,11 one cycle each; valid one cycle with data=1010; then IDLE.
REQ-031 Scenario 2: I=4'b0110, mask=0101, dwell=2 -> select 00 for 3 cycles, then 10 for 3 cycles, never 01 or 11; data=0100.
REQ-032 Scenario 3: mask=0000, start pulse -> busy stays 0 and no valid pulse; data unchanged.
REQ-033 Scenario 4: cont=1, mask=1111, dwell=0 -> valid every 4 cycles with busy continuously high; drop cont mid-sweep -> current sweep completes, then IDLE.
REQ-034 Scenario 5: rst during channel 2 of a sweep -> all outputs zero at once, no valid pulse; a fresh start afterwards sweeps normally.
REQ-035 Scenario 6: during a sweep, change mask to 0001 and pulse start -> current sweep is unaffected and no restart occurs.
